// File: rtl/hazard_stall_unit.sv
// Stall/flush control for load-use, mul/div busy and taken-branch squash.
// Build macro HAZARD_PERF_EN adds the saturating Stall_Cycles counter.
module hazard_stall_unit #(
    parameter int REG_W      = 5,
    parameter int MD_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_Rt,
    input  logic [REG_W-1:0] IF_ID_Rs,
    input  logic [REG_W-1:0] IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_ReadsHiLo,
    input  logic             IF_ID_IsMulDiv,
    input  logic             MD_Start,
    input  logic             EX_Branch_Taken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MD_Busy,
    output logic [31:0]      Stall_Cycles
);
    localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CW-1:0] MD_INIT = CW'(MD_LATENCY - 1);

    typedef enum logic {S_RUN, S_MD} state_t;

    state_t        state_q;
    logic [CW-1:0] md_cnt_q;
    logic          load_use;
    logic          md_hz;
    logic          stall;

    // A mul/div in flight is older than any branch, so squash never touches it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RUN;
            md_cnt_q <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (MD_Start) begin
                        state_q  <= S_MD;
                        md_cnt_q <= MD_INIT;
                    end
                end
                S_MD: begin
                    if (md_cnt_q != '0)
                        md_cnt_q <= md_cnt_q - CW'(1);
                    else
                        state_q <= S_RUN;
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign MD_Busy = (state_q == S_MD);

    always_comb begin
        load_use = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                   ((ID_EX_Rt == IF_ID_Rs) ||
                    (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
        md_hz    = (state_q == S_MD) && (IF_ID_ReadsHiLo || IF_ID_IsMulDiv);
        stall    = load_use || md_hz;
    end

    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (rst) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (EX_Branch_Taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (stall) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !EX_Branch_Taken && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign Stall_Cycles = stall_cnt_q;
`else
    assign Stall_Cycles = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a cycle-level reference model.
module tb_hazard_stall_unit;
    localparam int REG_W      = 5;
    localparam int MD_LATENCY = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ID_EX_MemRead = 1'b0;
    logic [REG_W-1:0] ID_EX_Rt = '0;
    logic [REG_W-1:0] IF_ID_Rs = '0;
    logic [REG_W-1:0] IF_ID_Rt = '0;
    logic             IF_ID_UsesRt = 1'b0;
    logic             IF_ID_ReadsHiLo = 1'b0;
    logic             IF_ID_IsMulDiv = 1'b0;
    logic             MD_Start = 1'b0;
    logic             EX_Branch_Taken = 1'b0;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             MD_Busy;
    logic [31:0]      Stall_Cycles;

    int vectors = 0;
    int miscompares = 0;

    hazard_stall_unit #(.REG_W(REG_W), .MD_LATENCY(MD_LATENCY)) dut (
        .clk(clk), .rst(rst),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
        .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_ReadsHiLo(IF_ID_ReadsHiLo),
        .IF_ID_IsMulDiv(IF_ID_IsMulDiv), .MD_Start(MD_Start),
        .EX_Branch_Taken(EX_Branch_Taken),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
        .MD_Busy(MD_Busy), .Stall_Cycles(Stall_Cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles and stall count
    int          busy_left = 0;
    longint      perf = 0;

    function automatic bit m_load_use();
        return ID_EX_MemRead && (ID_EX_Rt != 0) &&
               ((ID_EX_Rt == IF_ID_Rs) ||
                (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
    endfunction

    function automatic bit m_stall();
        return m_load_use() ||
               ((busy_left > 0) && (IF_ID_ReadsHiLo || IF_ID_IsMulDiv));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_left = 0;
            perf = 0;
        end else begin
            if (m_stall() && !EX_Branch_Taken && perf < 64'hFFFF_FFFF)
                perf = perf + 1;
            if (busy_left > 0)
                busy_left = busy_left - 1;
            else if (MD_Start)
                busy_left = MD_LATENCY;
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        logic [31:0] e_perf;
        if (rst)                  e = 4'b0011;
        else if (EX_Branch_Taken) e = 4'b1111;
        else if (m_stall())       e = 4'b0001;
        else                      e = 4'b1100;
`ifdef HAZARD_PERF_EN
        e_perf = perf[31:0];
`else
        e_perf = 32'd0;
`endif
        chk("PCWrite", {31'd0, PCWrite}, {31'd0, e[3]});
        chk("IF_ID_Write", {31'd0, IF_ID_Write}, {31'd0, e[2]});
        chk("IF_ID_Flush", {31'd0, IF_ID_Flush}, {31'd0, e[1]});
        chk("ID_EX_Flush", {31'd0, ID_EX_Flush}, {31'd0, e[0]});
        chk("MD_Busy", {31'd0, MD_Busy}, {31'd0, busy_left > 0});
        chk("Stall_Cycles", Stall_Cycles, e_perf);
    end

    task automatic idle();
        ID_EX_MemRead = 0; ID_EX_Rt = 0; IF_ID_Rs = 0; IF_ID_Rt = 0;
        IF_ID_UsesRt = 0; IF_ID_ReadsHiLo = 0; IF_ID_IsMulDiv = 0;
        MD_Start = 0; EX_Branch_Taken = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [3:0] ctl);
        chk({name, "_ctl"},
            {28'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush},
            {28'd0, ctl});
    endtask

    logic [31:0] perf_snap;

    initial begin
        idle();
        at_neg();
        pin("reset", 4'b0011);
        chk("reset_busy", {31'd0, MD_Busy}, 32'd0);
        chk("reset_perf", Stall_Cycles, 32'd0);
        next(); next();
        rst = 0;
        at_neg();
        pin("idle", 4'b1100);

        // Load-use on rs, then bubble clears MemRead
        next();
        ID_EX_MemRead = 1; ID_EX_Rt = 8; IF_ID_Rs = 8;
        at_neg();
        pin("lu_rs", 4'b0001);
        next();
        idle();
        at_neg();
        pin("lu_release", 4'b1100);

        // $zero destination never stalls
        next();
        ID_EX_MemRead = 1; ID_EX_Rt = 0; IF_ID_Rs = 0; IF_ID_Rt = 0;
        IF_ID_UsesRt = 1;
        at_neg();
        pin("lu_r0", 4'b1100);

        // rt match gated by UsesRt
        next();
        idle();
        ID_EX_MemRead = 1; ID_EX_Rt = 9; IF_ID_Rt = 9; IF_ID_Rs = 3;
        at_neg();
        pin("rt_unused", 4'b1100);
        next();
        IF_ID_UsesRt = 1;
        at_neg();
        pin("rt_used", 4'b0001);
        next();
        idle();

        // Mul/div window with HI/LO reader held and a re-issue at t+2
        MD_Start = 1; IF_ID_ReadsHiLo = 1;
        at_neg();
        pin("md_t0", 4'b1100);
        chk("md_t0_busy", {31'd0, MD_Busy}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            next();
            MD_Start = (k == 2);
            at_neg();
            chk($sformatf("md_busy_t%0d", k), {31'd0, MD_Busy},
                {31'd0, k <= 4});
            pin($sformatf("md_t%0d", k), (k <= 4) ? 4'b0001 : 4'b1100);
        end
        next();
        idle();

        // Branch beats a load-use stall and is not counted
        perf_snap = Stall_Cycles;
        ID_EX_MemRead = 1; ID_EX_Rt = 12; IF_ID_Rs = 12;
        EX_Branch_Taken = 1;
        at_neg();
        pin("br_over_stall", 4'b1111);
        next();
        idle();
        at_neg();
        chk("br_perf_hold", Stall_Cycles, perf_snap);

        // Third load-use stall via rt
        next();
        ID_EX_MemRead = 1; ID_EX_Rt = 17; IF_ID_Rt = 17; IF_ID_UsesRt = 1;
        at_neg();
        pin("lu_third", 4'b0001);
        next();
        idle();
        at_neg();
`ifdef HAZARD_PERF_EN
        chk("perf_total", Stall_Cycles, 32'd7);
`else
        chk("perf_total", Stall_Cycles, 32'd0);
`endif

        // Reset in the middle of a busy window
        next();
        MD_Start = 1;
        next();
        MD_Start = 0;
        next();
        #2;
        rst = 1;
        #1;
        chk("rst_mid_busy", {31'd0, MD_Busy}, 32'd0);
        pin("rst_mid_ctl", 4'b0011);
        next();
        rst = 0;
        IF_ID_ReadsHiLo = 1;
        at_neg();
        pin("post_rst_hilo", 4'b1100);
        chk("post_rst_busy", {31'd0, MD_Busy}, 32'd0);
        next();
        idle();
        next();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core; the stall/flush counterpart of the forwarding logic.
- Forwarding resolves producer→consumer hazards by bypass. This block handles the cases bypass cannot cover:
  - load-use
  - multi-cycle mul/div busy (HI/LO readers and structural conflicts)
  - taken-branch squash
- Drives PC/IF_ID write enables and the IF_ID/ID_EX flush (bubble) controls.

Parameters:
- REG_W, 5, register-specifier width
- MD_LATENCY, 4, cycles the mul/div unit is busy after issue (legal range 2..16)

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- ID_EX_MemRead  input  1  EX-stage instruction is a load
- ID_EX_Rt  input  REG_W  load destination register
- IF_ID_Rs  input  REG_W  ID-stage source register rs
- IF_ID_Rt  input  REG_W  ID-stage source register rt
- IF_ID_UsesRt  input  1  ID-stage instruction reads rt as a source
- IF_ID_ReadsHiLo  input  1  ID-stage instruction is mfhi or mflo
- IF_ID_IsMulDiv  input  1  ID-stage instruction is mult, multu, div or divu
- MD_Start  input  1  mul/div issuing in EX this cycle (single-cycle pulse)
- EX_Branch_Taken  input  1  branch/jump resolved taken in EX
- PCWrite  output  1  PC update enable
- IF_ID_Write  output  1  IF_ID register load enable
- IF_ID_Flush  output  1  clear IF_ID to a nop
- ID_EX_Flush  output  1  clear ID_EX control bits (insert bubble)
- MD_Busy  output  1  mul/div result not yet valid (registered)
- Stall_Cycles  output  32  performance counter (see Optional Feature)

Behaviour:
- FSM states:
  - S_RUN: mul/div idle.
  - S_MD: mul/div busy.
  - Down-counter md_cnt, width clog2(MD_LATENCY).
- Transitions:
  - S_RUN & MD_Start → S_MD, md_cnt ← MD_LATENCY-1.
  - S_MD & md_cnt!=0 → md_cnt ← md_cnt-1.
  - S_MD & md_cnt==0 → S_RUN.
  - Result: MD_Busy is high for exactly MD_LATENCY cycles, starting the cycle after MD_Start.
  - MD_Start while in S_MD is ignored; the counter does not restart.
- MD_Busy = (state==S_MD), registered.
- Hazard terms (combinational):
  - load_use = ID_EX_MemRead & (ID_EX_Rt!=0) & ((ID_EX_Rt==IF_ID_Rs) | (IF_ID_UsesRt & ID_EX_Rt==IF_ID_Rt))
  - md_hz = (state==S_MD) & (IF_ID_ReadsHiLo | IF_ID_IsMulDiv)
  - stall = load_use | md_hz
- Output priority, highest first:
  - rst: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1.
  - EX_Branch_Taken: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1. The stalled ID instruction is wrong-path and is discarded.
  - stall: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Flush=1.
  - otherwise: PCWrite=1, IF_ID_Write=1, both flushes 0.
- Load-use stalls last exactly 1 cycle: the bubble clears ID_EX_MemRead on the next cycle. No counter is involved.
- md_hz stalls hold until the cycle after md_cnt reaches 0, i.e. the first S_RUN cycle releases.
- EX_Branch_Taken does not affect the FSM: a mul/div in flight is older than the branch and completes.
- Reset:
  - Asynchronous; state←S_RUN, md_cnt←0, MD_Busy←0, Stall_Cycles←0.
  - Reset asserted mid-S_MD aborts the busy window immediately.
- Register 0: never causes a load-use stall.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - Stall_Cycles increments on every cycle with stall=1 and EX_Branch_Taken=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst.
- Undefined: Stall_Cycles is tied to 32'd0 and no counter flops are built. The port is present in both builds.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 → PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for 1 cycle. The same case with ID_EX_Rt=0 → no stall.
- rt gating: ID_EX_Rt=9, IF_ID_Rt=9, IF_ID_UsesRt=0 → no stall; IF_ID_UsesRt=1 → 1-cycle stall.
- Mul/div busy (MD_LATENCY=4): MD_Start pulse at cycle t → MD_Busy=1 for cycles t+1..t+4.
  - IF_ID_ReadsHiLo=1 held → stall during t+1..t+4, release at t+5.
  - A second MD_Start at t+2 does not extend the window.
- Branch over stall: load_use=1 and EX_Branch_Taken=1 in the same cycle → PCWrite=1, IF_ID_Flush=1, ID_EX_Flush=1. With HAZARD_PERF_EN defined, Stall_Cycles is unchanged.
- Reset mid-busy: rst asserted at t+2 of the window → MD_Busy=0 immediately (asynchronously). After release, the FSM is in S_RUN and IF_ID_ReadsHiLo causes no stall.
- Perf counter (HAZARD_PERF_EN): 3 load-use stalls and 4 md stalls → Stall_Cycles=7. In a build without the macro, Stall_Cycles=0.
